montgomery_domain_conv: RTL and testbench

MONTGOMERY_DOMAIN_CONV -- requirements
Module: montgomery_domain_conv

---
 rtl/montgomery_domain_conv.sv | 115 +++++++++++
 tb/tb_montgomery_domain_conv.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_domain_conv.sv
// Digit-serial Montgomery multiplier: y = a*b*R^-1 mod m, b = 1 (mode 0) or R^2 mod m (mode 1).
// Latency: done_irq_p D+3 cycles after an accepted enable_p (LOAD, D x ITER, REDUCE, DONE).
// No backpressure: enable_p is honoured only in IDLE; pulses while busy or in DONE are dropped.
module montgomery_domain_conv #(
  parameter int NBITS = 2048,
  parameter int WBITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_p,
  input  logic             mode,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] m,
  input  logic [NBITS-1:0] r2_red,
  input  logic [WBITS-1:0] m_inv,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_irq_p
);
  localparam int D  = NBITS / WBITS;
  localparam int TW = NBITS + 2;
  localparam int PW = NBITS + WBITS;
  localparam int SW = NBITS + WBITS + 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, REDUCE, DONE} state_t;

  state_t           state;
  logic [NBITS-1:0] a_sh;
  logic [NBITS-1:0] b_r;
  logic [NBITS-1:0] m_r;
  logic [WBITS-1:0] m_inv_r;
  logic [TW-1:0]    t_r;
  logic [CW-1:0]    cnt;

  logic [WBITS-1:0]   a_dig;
  logic [WBITS-1:0]   u;
  logic [WBITS-1:0]   q;
  logic [2*WBITS-1:0] ab_lo;
  logic [2*WBITS-1:0] qp;
  logic [PW-1:0]      p_ab;
  logic [PW-1:0]      p_qm;
  logic [SW-1:0]      sum;
  logic [TW-1:0]      t_nxt;
  logic [TW-1:0]      m_ext;
  logic [TW-1:0]      t_sub;

  // One Montgomery step; the low WBITS of sum are zero by construction of q.
  always_comb begin
    a_dig = a_sh[WBITS-1:0];
    ab_lo = (2*WBITS)'(a_dig) * (2*WBITS)'(b_r[WBITS-1:0]);
    u     = t_r[WBITS-1:0] + ab_lo[WBITS-1:0];
    qp    = (2*WBITS)'(u) * (2*WBITS)'(m_inv_r);
    q     = qp[WBITS-1:0];
    p_ab  = PW'(a_dig) * PW'(b_r);
    p_qm  = PW'(q) * PW'(m_r);
    sum   = SW'(t_r) + SW'(p_ab) + SW'(p_qm);
    t_nxt = sum[SW-1:WBITS];
    m_ext = TW'(m_r);
    t_sub = t_r - m_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      y          <= '0;
      busy       <= 1'b0;
      done_irq_p <= 1'b0;
      t_r        <= '0;
      cnt        <= '0;
      a_sh       <= '0;
      b_r        <= '0;
      m_r        <= '0;
      m_inv_r    <= '0;
    end else begin
      done_irq_p <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_p) begin
            a_sh    <= a;
            b_r     <= mode ? r2_red : NBITS'(1);
            m_r     <= m;
            m_inv_r <= m_inv;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
          t_r   <= '0;
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          t_r  <= t_nxt;
          a_sh <= a_sh >> WBITS;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) state <= REDUCE;
        end
        REDUCE: begin
          y          <= (t_r >= m_ext) ? t_sub[NBITS-1:0] : t_r[NBITS-1:0];
          busy       <= 1'b0;
          done_irq_p <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_montgomery_domain_conv.sv
// Directed checks on an 8-bit/2-bit instance plus random regression on 256-bit instances
// with digit widths 1, 8 and 32, against an arithmetic model of a*R^(+/-1) mod m.
module tb_montgomery_domain_conv;
  localparam int BN = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst;

  logic       s_en, s_mode, s_busy, s_done;
  logic [7:0] s_a, s_m, s_r2, s_y;
  logic [1:0] s_minv;

  montgomery_domain_conv #(.NBITS(8), .WBITS(2)) u_small (
    .clk(clk), .rst(rst), .enable_p(s_en), .mode(s_mode), .a(s_a), .m(s_m),
    .r2_red(s_r2), .m_inv(s_minv), .y(s_y), .busy(s_busy), .done_irq_p(s_done)
  );

  logic          b_en, b_mode;
  logic [BN-1:0] b_a, b_m, b_r2;
  logic [0:0]    b_minv1;
  logic [7:0]    b_minv8;
  logic [31:0]   b_minv32;
  logic [BN-1:0] y1, y8, y32;
  logic          bz1, bz8, bz32, d1, d8, d32;

  montgomery_domain_conv #(.NBITS(BN), .WBITS(1)) u_w1 (
    .clk(clk), .rst(rst), .enable_p(b_en), .mode(b_mode), .a(b_a), .m(b_m),
    .r2_red(b_r2), .m_inv(b_minv1), .y(y1), .busy(bz1), .done_irq_p(d1)
  );
  montgomery_domain_conv #(.NBITS(BN), .WBITS(8)) u_w8 (
    .clk(clk), .rst(rst), .enable_p(b_en), .mode(b_mode), .a(b_a), .m(b_m),
    .r2_red(b_r2), .m_inv(b_minv8), .y(y8), .busy(bz8), .done_irq_p(d8)
  );
  montgomery_domain_conv #(.NBITS(BN), .WBITS(32)) u_w32 (
    .clk(clk), .rst(rst), .enable_p(b_en), .mode(b_mode), .a(b_a), .m(b_m),
    .r2_red(b_r2), .m_inv(b_minv32), .y(y32), .busy(bz32), .done_irq_p(d32)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [BN-1:0] obs, input logic [BN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // -m^-1 mod 2^64 by Newton iteration; each step doubles the correct low bits.
  function automatic logic [63:0] neg_inv64(input logic [63:0] m0);
    logic [63:0] x;
    x = m0;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - m0 * x);
    return -x;
  endfunction

  function automatic logic [BN-1:0] r2_mod(input logic [BN-1:0] mm);
    logic [2*BN:0] big;
    logic [2*BN:0] rem;
    big = '0;
    big[2*BN] = 1'b1;
    rem = big % {{(BN+1){1'b0}}, mm};
    return rem[BN-1:0];
  endfunction

  function automatic logic [BN-1:0] to_mont(input logic [BN-1:0] av, input logic [BN-1:0] mm);
    logic [2*BN-1:0] p;
    logic [2*BN-1:0] rem;
    p = {av, {BN{1'b0}}};
    rem = p % {{BN{1'b0}}, mm};
    return rem[BN-1:0];
  endfunction

  // a * 2^-BN mod m: halve BN times, adding m first whenever the value is odd.
  function automatic logic [BN-1:0] from_mont(input logic [BN-1:0] av, input logic [BN-1:0] mm);
    logic [BN:0] x;
    x = {1'b0, av};
    for (int i = 0; i < BN; i++) begin
      if (x[0]) x = x + {1'b0, mm};
      x = x >> 1;
    end
    return x[BN-1:0];
  endfunction

  task automatic small_op(input logic md, input logic [7:0] av, input logic [7:0] exp_y,
                          input string tag, output int done_cyc);
    int t0, bc;
    logic [7:0] y0;
    bit y_held;
    @(negedge clk);
    s_mode = md; s_a = av; s_m = 8'd13; s_r2 = 8'd3; s_minv = 2'd3; s_en = 1'b1;
    t0 = cyc; y0 = s_y; y_held = 1'b1; bc = 0;
    @(negedge clk);
    s_en = 1'b0;
    for (int k = 0; k < 40 && s_done !== 1'b1; k++) begin
      if (s_busy === 1'b1) bc++;
      if (s_y !== y0) y_held = 1'b0;
      @(negedge clk);
    end
    done_cyc = cyc;
    chk({tag, ".latency"}, cyc - t0, 7);
    chk({tag, ".busy_cycles"}, bc, 6);
    chk({tag, ".busy_in_done"}, s_busy, 0);
    chk({tag, ".y_held"}, y_held, 1);
    chk({tag, ".y"}, s_y, exp_y);
  endtask

  initial begin
    int dc1, dc2, dcnt, t0, l1, l8, l32;
    logic [BN-1:0] mm, aa, ee, g1, g8, g32;
    logic [63:0] inv;

    rst = 1'b1;
    s_en = 1'b0; s_mode = 1'b0; s_a = '0; s_m = 8'd13; s_r2 = 8'd3; s_minv = 2'd3;
    b_en = 1'b0; b_mode = 1'b0; b_a = '0; b_m = 256'd1; b_r2 = '0;
    b_minv1 = '0; b_minv8 = '0; b_minv32 = '0;
    repeat (3) @(negedge clk);
    chk("rst.y", s_y, 0);
    chk("rst.busy", s_busy, 0);
    chk("rst.done", s_done, 0);
    chk("rst.y_w32", y32, 0);
    rst = 1'b0;

    small_op(1'b1, 8'd5, 8'd6, "req029", dc1);
    @(negedge clk);
    chk("req029.single_pulse", s_done, 0);

    small_op(1'b0, 8'd6, 8'd5, "req030.m0_a6", dc1);
    small_op(1'b1, 8'd12, 8'd4, "req030.m1_a12", dc1);
    small_op(1'b1, 8'd0, 8'd0, "req030.m1_a0", dc1);

    // Inputs change after capture and a stray start arrives mid-ITER.
    @(negedge clk);
    s_mode = 1'b1; s_a = 8'd5; s_m = 8'd13; s_r2 = 8'd3; s_minv = 2'd3; s_en = 1'b1;
    t0 = cyc;
    @(negedge clk);
    s_en = 1'b0; s_a = 8'd9; s_mode = 1'b0; s_m = 8'd11; s_r2 = 8'd7;
    @(negedge clk);
    @(negedge clk);
    s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    dcnt = 0; dc1 = -1;
    repeat (20) begin
      if (s_done === 1'b1) begin dcnt++; dc1 = cyc; end
      @(negedge clk);
    end
    chk("req031.done_count", dcnt, 1);
    chk("req031.latency", dc1 - t0, 7);
    chk("req031.y", s_y, 6);

    // Abort with reset in the third ITER cycle.
    @(negedge clk);
    s_mode = 1'b1; s_a = 8'd5; s_m = 8'd13; s_r2 = 8'd3; s_minv = 2'd3; s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("req032.rst_y", s_y, 0);
    chk("req032.rst_busy", s_busy, 0);
    dcnt = 0;
    repeat (12) begin
      if (s_done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("req032.no_done", dcnt, 0);
    chk("req032.y_after_abort", s_y, 0);
    small_op(1'b0, 8'd6, 8'd5, "req032.restart", dc1);

    // Start pulse landing in the DONE cycle must be dropped.
    s_mode = 1'b1; s_a = 8'd12; s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    dcnt = 0;
    repeat (10) begin
      if (s_busy === 1'b1 || s_done === 1'b1) dcnt++;
      @(negedge clk);
    end
    chk("req024.done_cycle_start_ignored", dcnt, 0);
    chk("req024.y_kept", s_y, 5);

    small_op(1'b1, 8'd5, 8'd6, "req033.first", dc1);
    small_op(1'b0, 8'd6, 8'd5, "req033.second", dc2);
    chk("req033.spacing", dc2 - dc1, 8);

    for (int n = 0; n < 8; n++) begin
      for (int w = 0; w < BN / 32; w++) begin
        mm[w*32 +: 32] = $urandom;
        aa[w*32 +: 32] = $urandom;
      end
      mm[0] = 1'b1;
      if (n % 2 == 0) mm[BN-1] = 1'b1;
      if (n == 6) mm = 256'd3;
      aa = aa % mm;
      if (n == 2) aa = mm - 256'd1;
      if (n == 4) aa = '0;
      b_mode = ((n / 2) % 2) == 1;
      ee = b_mode ? to_mont(aa, mm) : from_mont(aa, mm);
      inv = neg_inv64({32'd0, mm[31:0]});

      @(negedge clk);
      b_a = aa; b_m = mm; b_r2 = r2_mod(mm);
      b_minv1 = inv[0:0]; b_minv8 = inv[7:0]; b_minv32 = inv[31:0];
      b_en = 1'b1;
      t0 = cyc;
      @(negedge clk);
      b_en = 1'b0; b_a = ~aa; b_m = mm ^ 256'd2;
      l1 = -1; l8 = -1; l32 = -1;
      g1 = '0; g8 = '0; g32 = '0;
      for (int k = 0; k < 300 && (l1 < 0 || l8 < 0 || l32 < 0); k++) begin
        if (d1 === 1'b1 && l1 < 0) begin l1 = cyc - t0; g1 = y1; end
        if (d8 === 1'b1 && l8 < 0) begin l8 = cyc - t0; g8 = y8; end
        if (d32 === 1'b1 && l32 < 0) begin l32 = cyc - t0; g32 = y32; end
        @(negedge clk);
      end
      chk($sformatf("rand%0d.w1.latency", n), l1, 259);
      chk($sformatf("rand%0d.w8.latency", n), l8, 35);
      chk($sformatf("rand%0d.w32.latency", n), l32, 11);
      chk($sformatf("rand%0d.w1.y", n), g1, ee);
      chk($sformatf("rand%0d.w8.y", n), g8, ee);
      chk($sformatf("rand%0d.w32.y", n), g32, ee);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
